// File: rtl/conv_enc_pkg.sv
// Shared types, constants and the parity helper for the parametrised convolutional encoder.
// Polynomial constants are stored with bit 0 tapping the current input bit.
package conv_enc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StTail
  } conv_enc_state_e;

  localparam int unsigned KMaxDefault = 7;

  // Width used by conv_parity; windows and polynomials are zero-extended to it.
  localparam int unsigned PolyW = 32;

  localparam logic [2:0] PolyK3G0 = 3'b111;      // 7 octal
  localparam logic [2:0] PolyK3G1 = 3'b101;      // 5 octal
  localparam logic [3:0] PolyK4G0 = 4'b1011;     // 15 octal
  localparam logic [3:0] PolyK4G1 = 4'b1111;     // 17 octal
  localparam logic [4:0] PolyK5G0 = 5'b11001;    // 23 octal
  localparam logic [4:0] PolyK5G1 = 5'b10111;    // 35 octal
  localparam logic [6:0] PolyK7G0 = 7'b1001111;  // 171 octal
  localparam logic [6:0] PolyK7G1 = 7'b1101101;  // 133 octal

  function automatic logic conv_parity(input logic [PolyW-1:0] w,
                                       input logic [PolyW-1:0] poly,
                                       input int unsigned      k);
    logic acc;
    acc = 1'b0;
    for (int unsigned i = 0; i < PolyW; i++) begin
      if (i < k) acc ^= w[i] & poly[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/conv_encoder_gen_if.sv
// Valid/ready stream with a last flag; used for both the input bit stream and encoded symbols.
interface conv_encoder_gen_if #(
  parameter int unsigned W = 1
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  logic         last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/conv_enc_out_stage.sv
// Registered valid/ready output stage; load_o tells the encoder when a new symbol may enter.
module conv_enc_out_stage #(
  parameter int unsigned N_OUT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [N_OUT-1:0] data_i,
  input  logic             last_i,
  output logic             load_o,
  conv_encoder_gen_if.master m_if
);

  logic             valid_q;
  logic [N_OUT-1:0] data_q;
  logic             last_q;

  assign load_o = !valid_q || m_if.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_o) begin
      valid_q <= valid_i;
      last_q  <= valid_i & last_i;
      if (valid_i) data_q <= data_i;
    end
  end

  assign m_if.valid = valid_q;
  assign m_if.data  = data_q;
  assign m_if.last  = last_q;

endmodule

// File: rtl/conv_encoder_gen.sv
// Rate-1/N_OUT convolutional encoder with runtime K/polynomials, framing and optional zero tail.
// Configuration is captured on the first accepted bit of each frame.
module conv_encoder_gen
  import conv_enc_pkg::*;
#(
  parameter int unsigned K_MAX = KMaxDefault,
  parameter int unsigned N_OUT = 2,
  parameter int unsigned KW    = $clog2(K_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [KW-1:0]          cfg_k_i,
  input  logic [N_OUT*K_MAX-1:0] cfg_poly_i,
  input  logic                   cfg_tail_en_i,
  conv_encoder_gen_if.slave      s_if,
  conv_encoder_gen_if.master     m_if
);

  conv_enc_state_e state_q, state_d;
  logic [K_MAX-2:0]       hist_q, hist_d;
  logic [KW-1:0]          tail_cnt_q, tail_cnt_d;
  logic [KW-1:0]          k_q, k_d;
  logic [N_OUT*K_MAX-1:0] poly_q, poly_d;
  logic                   tail_en_q, tail_en_d;

  logic                   load, s_ready, accept, in_bit;
  logic                   out_valid, out_last;
  logic [KW-1:0]          k_cfg, k_cur;
  logic [N_OUT*K_MAX-1:0] poly_cur;
  logic                   tail_en_cur;
  logic [K_MAX-1:0]       win;
  logic [N_OUT-1:0]       sym;

  assign k_cfg = (32'(cfg_k_i) < 32'd2 || 32'(cfg_k_i) > K_MAX) ? KW'(K_MAX) : cfg_k_i;

  // In IDLE the next accept starts a frame, so it must already see the live config.
  assign k_cur       = (state_q == StIdle) ? k_cfg         : k_q;
  assign poly_cur    = (state_q == StIdle) ? cfg_poly_i    : poly_q;
  assign tail_en_cur = (state_q == StIdle) ? cfg_tail_en_i : tail_en_q;

  assign s_ready     = load && (state_q != StTail);
  assign s_if.ready  = s_ready;
  assign accept      = s_if.valid && s_ready;
  assign in_bit      = (state_q == StTail) ? 1'b0 : s_if.data[0];
  assign win         = {hist_q, in_bit};

  always_comb begin
    sym = '0;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      sym[j] = conv_parity(PolyW'(win), PolyW'(poly_cur[j*K_MAX +: K_MAX]), 32'(k_cur));
    end
  end

  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    tail_cnt_d = tail_cnt_q;
    k_d        = k_q;
    poly_d     = poly_q;
    tail_en_d  = tail_en_q;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    case (state_q)
      StIdle, StData: begin
        if (accept) begin
          out_valid = 1'b1;
          hist_d    = {hist_q[K_MAX-3:0], in_bit};
          state_d   = StData;
          if (state_q == StIdle) begin
            k_d       = k_cur;
            poly_d    = poly_cur;
            tail_en_d = tail_en_cur;
          end
          if (s_if.last) begin
            if (tail_en_cur) begin
              state_d    = StTail;
              tail_cnt_d = k_cur - KW'(2);
            end else begin
              out_last = 1'b1;
              hist_d   = '0;
              state_d  = StIdle;
            end
          end
        end
      end
      StTail: begin
        if (load) begin
          out_valid = 1'b1;
          hist_d    = {hist_q[K_MAX-3:0], 1'b0};
          if (tail_cnt_q == '0) begin
            out_last = 1'b1;
            hist_d   = '0;
            state_d  = StIdle;
          end else begin
            tail_cnt_d = tail_cnt_q - KW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hist_q     <= '0;
      tail_cnt_q <= '0;
      k_q        <= KW'(K_MAX);
      poly_q     <= '0;
      tail_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      tail_cnt_q <= tail_cnt_d;
      k_q        <= k_d;
      poly_q     <= poly_d;
      tail_en_q  <= tail_en_d;
    end
  end

  conv_enc_out_stage #(
    .N_OUT (N_OUT)
  ) u_out_stage (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (out_valid),
    .data_i  (sym),
    .last_i  (out_last),
    .load_o  (load),
    .m_if    (m_if)
  );

endmodule

// File: tb/tb_conv_encoder_gen.sv
// Directed and randomised bench for conv_encoder_gen against a frame-level reference model.
module tb_conv_encoder_gen;

  logic        clk;
  logic        rst_n;
  logic [2:0]  cfg_k;
  logic [13:0] cfg_poly;
  logic        cfg_tail_en;

  conv_encoder_gen_if #(.W(1)) s_bus ();
  conv_encoder_gen_if #(.W(2)) m_bus ();

  conv_encoder_gen #(
    .K_MAX (7),
    .N_OUT (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_k_i       (cfg_k),
    .cfg_poly_i    (cfg_poly),
    .cfg_tail_en_i (cfg_tail_en),
    .s_if          (s_bus),
    .m_if          (m_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] exp_d[$];
  bit         exp_l[$];

  localparam logic [6:0] K7G0 = 7'b1001111;
  localparam logic [6:0] K7G1 = 7'b1101101;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_cfg(input int k, input logic [6:0] p0, input logic [6:0] p1, input bit t);
    cfg_k       = 3'(k);
    cfg_poly    = {p1, p0};
    cfg_tail_en = t;
  endtask

  task automatic push(input logic [1:0] d, input bit l);
    exp_d.push_back(d);
    exp_l.push_back(l);
  endtask

  // Reference: output n is the parity of the last k frame bits (zeros before frame start).
  task automatic model_frame(input bit bits[$]);
    bit         seq[$];
    int         kk;
    logic [1:0] r;
    kk  = (int'(cfg_k) < 2) ? 7 : int'(cfg_k);
    seq = bits;
    if (cfg_tail_en) for (int t = 0; t < kk - 1; t++) seq.push_back(1'b0);
    for (int n = 0; n < seq.size(); n++) begin
      r = 2'b00;
      for (int j = 0; j < 2; j++)
        for (int i = 0; i < kk; i++)
          if (n - i >= 0 && seq[n-i] && cfg_poly[j*7+i]) r[j] = ~r[j];
      push(r, n == seq.size() - 1);
    end
  endtask

  // rmode: 0 ready, 1 random, 2 stall cycles 2..4, 3 stall 4 cycles once all bits are in.
  task automatic send_frame(input bit bits[$], input int rmode, input bit scramble);
    int         idx = 0, cyc = 0, post = 0, pending;
    bit         done, stall = 1'b0, do_scr = 1'b0;
    logic [1:0] pd = 2'b00;
    logic       pl = 1'b0;
    while (!(idx >= bits.size() && exp_d.size() == 0) && cyc < 400) begin
      @(negedge clk);
      if (do_scr) begin
        set_cfg(4, 7'b0001011, 7'b0001111, 1'b0);
        do_scr = 1'b0;
      end
      done = (idx >= bits.size());
      case (rmode)
        1:       m_bus.ready = ($urandom_range(0, 2) != 0);
        2:       m_bus.ready = !(cyc >= 2 && cyc <= 4);
        3:       m_bus.ready = !(done && post < 4);
        default: m_bus.ready = 1'b1;
      endcase
      if (done) post++;
      pending = exp_d.size() - (m_bus.valid ? 1 : 0);
      if (!done) begin
        s_bus.valid = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_bus.data  = bits[idx];
        s_bus.last  = (idx == bits.size() - 1);
      end else begin
        // Offer a bit while tail beats are still to be generated; it must be refused.
        s_bus.valid = (pending > 0);
        s_bus.data  = 1'b1;
        s_bus.last  = 1'b0;
      end
      #1;
      if (done && pending > 0) check("tail_sready", 32'(s_bus.ready), 32'd0);
      if (m_bus.valid && !m_bus.ready) check("bp_sready", 32'(s_bus.ready), 32'd0);
      if (stall) begin
        check("bp_valid", 32'(m_bus.valid), 32'd1);
        check("bp_data", 32'(m_bus.data), 32'(pd));
        check("bp_last", 32'(m_bus.last), 32'(pl));
      end
      if (m_bus.valid && m_bus.ready) begin
        if (exp_d.size() == 0) begin
          check("extra_beat", 32'(m_bus.valid), 32'd0);
        end else begin
          check("m_data", 32'(m_bus.data), 32'(exp_d.pop_front()));
          check("m_last", 32'(m_bus.last), 32'(exp_l.pop_front()));
        end
      end
      stall = m_bus.valid && !m_bus.ready;
      pd    = m_bus.data;
      pl    = m_bus.last;
      if (!done && s_bus.valid && s_bus.ready) begin
        if (idx == 0 && scramble) do_scr = 1'b1;
        idx++;
      end
      cyc++;
    end
    check("frame_drained", 32'(exp_d.size()), 32'd0);
    check("frame_bits_sent", 32'(idx), 32'(bits.size()));
    exp_d.delete();
    exp_l.delete();
    s_bus.valid = 1'b0;
  endtask

  initial begin
    bit bits[$];
    int len;

    rst_n       = 1'b0;
    s_bus.valid = 1'b0;
    s_bus.data  = 1'b0;
    s_bus.last  = 1'b0;
    m_bus.ready = 1'b0;
    set_cfg(3, 7'b0000111, 7'b0000101, 1'b1);
    #1;
    check("rst_m_valid", 32'(m_bus.valid), 32'd0);
    check("rst_m_data", 32'(m_bus.data), 32'd0);
    check("rst_m_last", 32'(m_bus.last), 32'd0);
    check("rst_s_ready", 32'(s_bus.ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // K=3 (7,5) with tail
    push(2'b11, 0); push(2'b01, 0); push(2'b00, 0); push(2'b10, 0);
    push(2'b10, 0); push(2'b11, 1);
    send_frame('{1, 0, 1, 1}, 0, 0);

    // Same without tail, then a fresh frame starts from the zero state
    set_cfg(3, 7'b0000111, 7'b0000101, 1'b0);
    push(2'b11, 0); push(2'b01, 0); push(2'b00, 0); push(2'b10, 1);
    send_frame('{1, 0, 1, 1}, 0, 0);
    push(2'b11, 1);
    send_frame('{1}, 0, 0);

    // K=7 impulse response
    set_cfg(7, K7G0, K7G1, 1'b1);
    for (int i = 0; i < 7; i++) push({K7G1[i], K7G0[i]}, i == 6);
    send_frame('{1}, 0, 0);

    // Backpressure mid-frame, then during the tail
    set_cfg(3, 7'b0000111, 7'b0000101, 1'b1);
    push(2'b11, 0); push(2'b01, 0); push(2'b00, 0); push(2'b10, 0);
    push(2'b10, 0); push(2'b11, 1);
    send_frame('{1, 0, 1, 1}, 2, 0);
    set_cfg(7, K7G0, K7G1, 1'b1);
    for (int i = 0; i < 7; i++) push({K7G1[i], K7G0[i]}, i == 6);
    send_frame('{1}, 3, 0);

    // Config changed after the first beat is ignored until the next frame
    set_cfg(3, 7'b0000111, 7'b0000101, 1'b1);
    push(2'b11, 0); push(2'b01, 0); push(2'b00, 0); push(2'b10, 0);
    push(2'b10, 0); push(2'b11, 1);
    send_frame('{1, 0, 1, 1}, 0, 1);
    check("scramble_k", 32'(cfg_k), 32'd4);
    model_frame('{1, 1, 0, 1, 0});
    send_frame('{1, 1, 0, 1, 0}, 0, 0);

    // Asynchronous reset in the middle of the tail
    set_cfg(7, K7G0, K7G1, 1'b1);
    @(negedge clk);
    m_bus.ready = 1'b1;
    s_bus.valid = 1'b1;
    s_bus.data  = 1'b1;
    s_bus.last  = 1'b1;
    @(negedge clk);
    s_bus.valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_valid", 32'(m_bus.valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_m_valid", 32'(m_bus.valid), 32'd0);
    check("arst_m_data", 32'(m_bus.data), 32'd0);
    check("arst_m_last", 32'(m_bus.last), 32'd0);
    check("arst_s_ready", 32'(s_bus.ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    set_cfg(3, 7'b0000111, 7'b0000101, 1'b1);
    push(2'b11, 0); push(2'b01, 0); push(2'b11, 1);
    send_frame('{1}, 0, 0);

    // Randomised frames, including out-of-range K (0/1 behave as K=7)
    for (int f = 0; f < 10; f++) begin
      set_cfg($urandom_range(0, 7), 7'($urandom), 7'($urandom), 1'($urandom));
      len = $urandom_range(1, 10);
      bits.delete();
      for (int i = 0; i < len; i++) bits.push_back(1'($urandom));
      model_frame(bits);
      send_frame(bits, 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_encoder_gen.md
# conv_encoder_gen

Parametrised rate-1/N convolutional encoder, the successor to the fixed two-output, four-mode encoder. It has runtime-programmable constraint length and generator polynomials, valid/ready streaming on both sides, frame delimiting, and optional zero-tail termination. It sits between the bit-serial framer and the modulator/interleaver input.

## Interface
- `K_MAX`, 7: largest supported constraint length (≥3).
- `N_OUT`, 2: outputs per input bit (code rate 1/N_OUT, 2..4).
- `KW`, $clog2(K_MAX+1): width of `cfg_k`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_k` in KW: constraint length; values outside 2..K_MAX are treated as K_MAX.
- `cfg_poly` in N_OUT*K_MAX: polynomial j occupies bits [j*K_MAX +: K_MAX]; bit i taps the input i steps ago (bit 0 = current bit).
- `cfg_tail_en` in 1: when set, append K-1 zero tail bits per frame.
- `s_valid` in 1, `s_ready` out 1, `s_data` in 1, `s_last` in 1: input bit stream.
- `m_valid` out 1, `m_ready` in 1, `m_data` out N_OUT, `m_last` out 1: encoded symbol; `m_data[j]` is the polynomial-j output.

## Operation
- States: IDLE, DATA, TAIL.
- Config (`cfg_k`, `cfg_poly`, `cfg_tail_en`) is latched on the first accepted beat of a frame (the IDLE accept). Config changes mid-frame are ignored.
- Window: `w = {hist[K_MAX-2:0], in_bit}`, where `hist` holds the previous K_MAX-1 inputs with the newest in bit 0. Taps with index ≥ latched K are masked to 0.
- Output: `m_data[j] = ^(w & poly_j & kmask)`.
- `load = !m_valid || m_ready`. The output register and `hist` update only on `load`.
- IDLE/DATA:
  - `s_ready = load`.
  - On `s_valid && s_ready`, encode `s_data`, shift it into `hist`, and set `m_valid=1`.
  - IDLE goes to DATA on an accept without `s_last`.
- On an accepted `s_last`:
  - If `cfg_tail_en`: go to TAIL with `tail_cnt = K-2` and `m_last=0`.
  - Otherwise: set `m_last=1`, clear `hist`, and go to IDLE.
- TAIL:
  - `s_ready=0`.
  - Each `load` encodes `in_bit=0`, shifts, and sets `m_valid=1`.
  - At `tail_cnt==0`: set `m_last=1`, clear `hist`, and go to IDLE. Otherwise decrement `tail_cnt`.
- Each frame starts from the all-zero encoder state.
- Reset values: `m_valid=0`, `m_data=0`, `m_last=0`, state=IDLE, `hist=0`, `tail_cnt=0`.
  - `s_ready` is 1 combinationally once the flops are in their reset state.
  - Reset mid-frame discards the frame and any pending output with no completion beat.

## Timing
- Latency is 1 cycle: an input accepted at edge n gives `m_valid`/`m_data` after edge n.
- Throughput is 1 symbol/cycle while `m_ready=1`.
- A frame of L bits costs L + (K-1 if tail enabled) output beats.
- Backpressure: while `m_valid && !m_ready`, `m_data`/`m_last` are held stable and `s_ready=0`.
- A new frame's first bit may be accepted on the cycle the last tail beat is consumed, with no bubble, provided that beat's `load` occurred.
- An `s_last` accepted while `cfg_tail_en=0` and K=2 still produces exactly one beat with `m_last`.
- `s_valid` asserted during TAIL is not accepted; it is held upstream.

## Structure
- Package `conv_enc_pkg` holds:
  - state enum `conv_enc_state_e`;
  - default `K_MAX`;
  - standard polynomial constants: K=3 (7,5)₈, K=4 (15,17)₈, K=5 (23,35)₈, K=7 (171,133)₈, bit-reversed to the bit-0-current convention;
  - function `conv_parity(w, poly, k)`.
- One sub-module is natural: `conv_enc_out_stage`, the registered valid/ready output holding `m_data`/`m_last`, which generates `load`.

## Test plan
- K=3, polys 3'b111/3'b101, tail on, input 1,0,1,1 (`s_last` on 4th), `m_ready=1`: `m_data` = 2'b11, 01, 00, 10, 10, 11, with `m_last` only on the 6th beat.
- Same stimulus with `cfg_tail_en=0`: 4 beats 11, 01, 00, 10, with `m_last` on the 4th. The next frame starts from the zero state: input 1 gives 11.
- K=7, polys 171/133 (reversed), single-bit frame "1" with tail: 7 beats, where beat i equals {poly1[i], poly0[i]} (the impulse response), and `m_last` is on beat 7.
- Backpressure: drop `m_ready` for 3 cycles mid-frame. `m_data` stays stable, `s_ready=0`, and the full sequence is unchanged. Hold `m_ready=0` during TAIL: the tail count is preserved.
- Change `cfg_poly`/`cfg_k` after the first beat of a frame: the output still matches the latched config. The new config applies from the next frame.
- Assert `rst_n=0` in the middle of TAIL: all outputs go to 0 immediately (async). After release, a K=3 frame "1" with tail yields 11, 01, 11.
